baccarat_match_ctrl: RTL and testbench
======================================

Name: baccarat_match_ctrl

Overview:
- Parametrised successor to the single-hand baccarat dealer FSM.
- Sequences repeated baccarat rounds (deal, third-card rules, scoring) across a match of ROUNDS rounds with start/busy handshake.
- Keeps saturating player/dealer/tie tallies, auto-clears hands between rounds, holds result lights for HOLD_CYCLES.
- Drives the card-register load strobes; scores come back from the existing card/score datapath.

Parameters:
- ROUNDS, 8, rounds per match; 0 = endless match (never enters DONE).
- HOLD_CYCLES, 4, slow_clock cycles the result lights are held before the next round; minimum 1.
- TALLY_W, 8, width of win/tie tally counters.
- RND_W, 8, width of round counter; must hold ROUNDS.

Ports:
- slow_clock  in  1  clock
- resetb  in  1  synchronous active-low reset
- start  in  1  begin match; sampled only in IDLE or DONE
- pscore  in  4  player hand score (0-9), valid the cycle after a load strobe
- dscore  in  4  dealer hand score (0-9)
- pcard3  in  4  player third-card value (0-9)
- clear_hands  out  1  one-cycle strobe that zeroes all card registers
- load_pcard  out  3  one-hot load strobes, bit i = player card i+1
- load_dcard  out  3  one-hot load strobes, bit i = dealer card i+1
- player_win_light  out  1  player won (both lights on = tie)
- dealer_win_light  out  1  dealer won
- player_wins  out  TALLY_W  player win tally
- dealer_wins  out  TALLY_W  dealer win tally
- ties  out  TALLY_W  tie tally
- round_num  out  RND_W  rounds completed in current match
- busy  out  1  high in every state except IDLE and DONE
- match_done  out  1  high in DONE

Behaviour:
- Reset: resetb is synchronous and active-low, clocked on slow_clock. Reset is sampled every edge and takes priority over everything, including mid-round. It puts the FSM in IDLE and drives every output 0, including all tallies and round_num.
- Outputs are registered or Moore-decoded from present state; there is no combinational path from inputs to load strobes.
- States: IDLE, CLR, P1, D1, P2, D2, DEC1, P3, DEC2, D3, SCORE, HOLD, DONE.
- IDLE: start=1 zeroes tallies and round_num, then goes to CLR.
- CLR: clear_hands=1, then P1.
- P1, D1, P2, D2: assert load_pcard[0], load_dcard[0], load_pcard[1], load_dcard[1] respectively, one cycle each, in that order.
- D2 goes to DEC1. Scores are valid in DEC1 because the card register captures on the same edge the FSM leaves D2.
- DEC1 (checked in this order):
  - dscore in {8,9} or pscore in {8,9} -> SCORE.
  - pscore 0-5 -> P3.
  - pscore 6-7: dscore <= 5 -> D3, else SCORE.
- P3: load_pcard[2]=1, then DEC2.
- DEC2 (banker rule, on dscore):
  - 7 -> SCORE.
  - 6 -> D3 if pcard3 in {6,7}.
  - 5 -> D3 if pcard3 in 4-7.
  - 4 -> D3 if pcard3 in 2-7.
  - 3 -> D3 unless pcard3 = 8.
  - 0-2 -> D3.
  - Any case above that does not go to D3 goes to SCORE.
- D3: load_dcard[2]=1, then SCORE.
- SCORE (one cycle):
  - Compare pscore and dscore.
  - Latch the lights: player>dealer -> player light only; dealer>player -> dealer light only; equal -> both lights.
  - Increment the matching tally, saturating at all-ones (no wrap).
  - Increment round_num, saturating at all-ones.
  - Go to HOLD.
- HOLD:
  - Lights stay on; wait HOLD_CYCLES cycles.
  - Then go to DONE if ROUNDS != 0 and round_num == ROUNDS, else CLR.
  - Lights clear when CLR is entered.
- DONE:
  - Lights, tallies and round_num are held.
  - start=1 restarts the match: tallies and round_num are zeroed, and the FSM goes to CLR.
- start is ignored while busy=1.
- Out-of-range score (>9) at DEC1/DEC2: treated as a non-natural, non-drawing score, i.e. the rules above are applied using compare-only logic. No special state.
- Exactly one load strobe bit or clear_hands is high in any cycle; never two.

Optional Feature:
- Macro BACCARAT_SCORE_CHECK_EN.
- Defined:
  - Adds output score_err (1 bit).
  - score_err is set sticky if pscore, dscore or pcard3 > 9 is seen in DEC1, DEC2 or SCORE.
  - That round is not tallied and round_num does not increment; the FSM goes straight to HOLD with both lights off.
  - score_err clears only on reset or match restart.
- Undefined: no score_err port, and no range checking.

Decomposition:
- Package baccarat_pkg holds:
  - state enum typedef match_state_t (4 bits);
  - constants NATURAL_LO=8, PLAYER_STAND=6, BANKER_STAND=7;
  - function banker_draws(dscore, pcard3) implementing the DEC2 table.
- One sub-module, baccarat_tally: three saturating TALLY_W counters plus the round counter, with clear and increment-select inputs. The FSM remains in baccarat_match_ctrl.

Test Plan:
- Natural: ROUNDS=1, HOLD_CYCLES=1, start; scores at DEC1 pscore=8, dscore=3 -> no P3/D3 strobes; player_win_light=1; player_wins=1; match_done=1 one cycle after HOLD.
- Player draws, banker stands: pscore=4, dscore=6, pcard3=5 -> load_pcard[2] pulses once, no load_dcard[2]; final pscore=9 vs dscore=6 -> player_wins increments.
- Banker draws on 3: pscore=2, dscore=3, pcard3=7 -> P3 then D3 strobes. Repeat with pcard3=8 -> D3 skipped.
- Tie and saturation: TALLY_W=2, force equal scores for 5 rounds -> both lights lit each SCORE; ties stops at 3.
- Reset mid-round: assert resetb=0 in P2 -> next edge is IDLE, all outputs 0; start then gives a clean CLR->P1 sequence.
- Endless and start gating: ROUNDS=0 -> round_num keeps incrementing and match_done never asserts; start pulses while busy have no effect.

Source files
------------

// File: rtl/baccarat_match_ctrl_pkg.sv
// Shared types and rule helpers for the baccarat match controller.
// States, rule thresholds and the banker third-card table.
package baccarat_pkg;

    typedef enum logic [3:0] {
        S_IDLE, S_CLR, S_P1, S_D1, S_P2, S_D2, S_DEC1,
        S_P3, S_DEC2, S_D3, S_SCORE, S_HOLD, S_DONE
    } match_state_t;

    localparam logic [3:0] NATURAL_LO   = 4'd8;
    localparam logic [3:0] PLAYER_STAND = 4'd6;
    localparam logic [3:0] BANKER_STAND = 4'd7;

    function automatic logic is_natural(input logic [3:0] s);
        return (s >= NATURAL_LO) && (s <= 4'd9);
    endfunction

    // Banker decision once the player has taken a third card.
    // Anything out of range falls through to "stand".
    function automatic logic banker_draws(input logic [3:0] dscore,
                                          input logic [3:0] pcard3);
        logic d;
        d = 1'b0;
        if (dscore < BANKER_STAND) begin
            case (dscore)
                4'd6:    d = (pcard3 == 4'd6) || (pcard3 == 4'd7);
                4'd5:    d = (pcard3 >= 4'd4) && (pcard3 <= 4'd7);
                4'd4:    d = (pcard3 >= 4'd2) && (pcard3 <= 4'd7);
                4'd3:    d = (pcard3 != 4'd8);
                default: d = 1'b1;
            endcase
        end
        return d;
    endfunction

endpackage

// File: rtl/baccarat_tally.sv
// Saturating win/tie tallies and completed-round counter for one match.
module baccarat_tally #(
    parameter int TALLY_W = 8,
    parameter int RND_W   = 8
) (
    input  logic               slow_clock,
    input  logic               resetb,
    input  logic               i_clear,
    input  logic               i_inc_p,
    input  logic               i_inc_d,
    input  logic               i_inc_t,
    input  logic               i_inc_rnd,
    output logic [TALLY_W-1:0] o_player_wins,
    output logic [TALLY_W-1:0] o_dealer_wins,
    output logic [TALLY_W-1:0] o_ties,
    output logic [RND_W-1:0]   o_round_num
);

    logic [TALLY_W-1:0] r_p, r_d, r_t;
    logic [RND_W-1:0]   r_rnd;

    // Counters stick at all-ones rather than wrapping.
    always_ff @(posedge slow_clock) begin
        if (!resetb || i_clear) begin
            r_p   <= '0;
            r_d   <= '0;
            r_t   <= '0;
            r_rnd <= '0;
        end else begin
            if (i_inc_p && (r_p != '1))     r_p   <= r_p + 1'b1;
            if (i_inc_d && (r_d != '1))     r_d   <= r_d + 1'b1;
            if (i_inc_t && (r_t != '1))     r_t   <= r_t + 1'b1;
            if (i_inc_rnd && (r_rnd != '1)) r_rnd <= r_rnd + 1'b1;
        end
    end

    assign o_player_wins = r_p;
    assign o_dealer_wins = r_d;
    assign o_ties        = r_t;
    assign o_round_num   = r_rnd;

endmodule

// File: rtl/baccarat_match_ctrl.sv
// Multi-round baccarat dealer: sequences card loads, applies draw rules, scores and tallies.
// Optional BACCARAT_SCORE_CHECK_EN adds a sticky score_err and voids rounds with scores > 9.
module baccarat_match_ctrl
    import baccarat_pkg::*;
#(
    parameter int ROUNDS      = 8,
    parameter int HOLD_CYCLES = 4,
    parameter int TALLY_W     = 8,
    parameter int RND_W       = 8
) (
    input  logic               slow_clock,
    input  logic               resetb,
    input  logic               start,
    input  logic [3:0]         pscore,
    input  logic [3:0]         dscore,
    input  logic [3:0]         pcard3,
    output logic               clear_hands,
    output logic [2:0]         load_pcard,
    output logic [2:0]         load_dcard,
    output logic               player_win_light,
    output logic               dealer_win_light,
    output logic [TALLY_W-1:0] player_wins,
    output logic [TALLY_W-1:0] dealer_wins,
    output logic [TALLY_W-1:0] ties,
    output logic [RND_W-1:0]   round_num,
    output logic               busy,
    output logic               match_done
`ifdef BACCARAT_SCORE_CHECK_EN
   ,output logic               score_err
`endif
);

    localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    match_state_t  r_state, w_next;
    logic [HW-1:0] r_hold;
    logic          r_plight, r_dlight;
    logic          w_hold_done, w_last, w_bad, w_score, w_restart;

    always_ff @(posedge slow_clock) begin
        if (!resetb) r_state <= S_IDLE;
        else         r_state <= w_next;
    end

    always_ff @(posedge slow_clock) begin
        if (!resetb || r_state != S_HOLD) r_hold <= '0;
        else                              r_hold <= r_hold + 1'b1;
    end

    assign w_hold_done = (r_hold == HW'(HOLD_CYCLES - 1));
    assign w_last      = (ROUNDS != 0) && (round_num == RND_W'(ROUNDS));
    assign w_restart   = start && (r_state == S_IDLE || r_state == S_DONE);

`ifdef BACCARAT_SCORE_CHECK_EN
    assign w_bad = (pscore > 4'd9 || dscore > 4'd9 || pcard3 > 4'd9) &&
                   (r_state == S_DEC1 || r_state == S_DEC2 || r_state == S_SCORE);
`else
    assign w_bad = 1'b0;
`endif

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next = S_CLR;
            S_CLR:   w_next = S_P1;
            S_P1:    w_next = S_D1;
            S_D1:    w_next = S_P2;
            S_P2:    w_next = S_D2;
            S_D2:    w_next = S_DEC1;
            S_DEC1: begin
                if (w_bad)                                     w_next = S_HOLD;
                else if (is_natural(pscore) || is_natural(dscore)) w_next = S_SCORE;
                else if (pscore < PLAYER_STAND)                w_next = S_P3;
                else if (pscore < NATURAL_LO && dscore <= 4'd5) w_next = S_D3;
                else                                           w_next = S_SCORE;
            end
            S_P3:    w_next = S_DEC2;
            S_DEC2: begin
                if (w_bad)                             w_next = S_HOLD;
                else if (banker_draws(dscore, pcard3)) w_next = S_D3;
                else                                   w_next = S_SCORE;
            end
            S_D3:    w_next = S_SCORE;
            S_SCORE: w_next = S_HOLD;
            S_HOLD:  if (w_hold_done) w_next = w_last ? S_DONE : S_CLR;
            S_DONE:  if (start) w_next = S_CLR;
            default: w_next = S_IDLE;
        endcase
    end

    assign w_score = (r_state == S_SCORE) && !w_bad;

    // Lights latch at SCORE and drop as the next round's CLR begins.
    always_ff @(posedge slow_clock) begin
        if (!resetb || w_next == S_CLR) begin
            r_plight <= 1'b0;
            r_dlight <= 1'b0;
        end else if (w_score) begin
            r_plight <= (pscore >= dscore);
            r_dlight <= (dscore >= pscore);
        end
    end

`ifdef BACCARAT_SCORE_CHECK_EN
    always_ff @(posedge slow_clock) begin
        if (!resetb || w_restart) score_err <= 1'b0;
        else if (w_bad)           score_err <= 1'b1;
    end
`endif

    baccarat_tally #(.TALLY_W(TALLY_W), .RND_W(RND_W)) u_tally (
        .slow_clock    (slow_clock),
        .resetb        (resetb),
        .i_clear       (w_restart),
        .i_inc_p       (w_score && (pscore > dscore)),
        .i_inc_d       (w_score && (dscore > pscore)),
        .i_inc_t       (w_score && (pscore == dscore)),
        .i_inc_rnd     (w_score),
        .o_player_wins (player_wins),
        .o_dealer_wins (dealer_wins),
        .o_ties        (ties),
        .o_round_num   (round_num)
    );

    assign clear_hands      = (r_state == S_CLR);
    assign load_pcard       = {r_state == S_P3, r_state == S_P2, r_state == S_P1};
    assign load_dcard       = {r_state == S_D3, r_state == S_D2, r_state == S_D1};
    assign player_win_light = r_plight;
    assign dealer_win_light = r_dlight;
    assign busy             = (r_state != S_IDLE) && (r_state != S_DONE);
    assign match_done       = (r_state == S_DONE);

endmodule

// File: tb/tb_baccarat_match_ctrl.sv
// Randomized bench: emulates the card datapath and scores each round with a rule-level model.
module tb_baccarat_match_ctrl;

    localparam int ROUNDS = 6;
    localparam int HOLD   = 2;
    localparam int TW     = 2;
    localparam int RW     = 8;
    localparam int TMAX   = (1 << TW) - 1;

    logic          slow_clock = 1'b0;
    logic          resetb = 1'b0;
    logic          start = 1'b0;
    logic [3:0]    pscore, dscore, pcard3;
    logic          clear_hands;
    logic [2:0]    load_pcard, load_dcard;
    logic          player_win_light, dealer_win_light;
    logic [TW-1:0] player_wins, dealer_wins, ties;
    logic [RW-1:0] round_num;
    logic          busy, match_done;

    int n_chk = 0;
    int n_err = 0;

    baccarat_match_ctrl #(.ROUNDS(ROUNDS), .HOLD_CYCLES(HOLD), .TALLY_W(TW), .RND_W(RW)) dut (
        .slow_clock(slow_clock), .resetb(resetb), .start(start),
        .pscore(pscore), .dscore(dscore), .pcard3(pcard3),
        .clear_hands(clear_hands), .load_pcard(load_pcard), .load_dcard(load_dcard),
        .player_win_light(player_win_light), .dealer_win_light(dealer_win_light),
        .player_wins(player_wins), .dealer_wins(dealer_wins), .ties(ties),
        .round_num(round_num), .busy(busy), .match_done(match_done)
    );

    always #5 slow_clock = ~slow_clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Card registers: a fresh deck is drawn for every round at clear_hands.
    bit         tie_mode = 1'b0;
    logic [3:0] deck_p[3] = '{4'd0, 4'd0, 4'd0};
    logic [3:0] deck_d[3] = '{4'd0, 4'd0, 4'd0};
    logic [3:0] pc[3]     = '{4'd0, 4'd0, 4'd0};
    logic [3:0] dc[3]     = '{4'd0, 4'd0, 4'd0};

    always @(posedge slow_clock) begin
        if (clear_hands) begin
            for (int i = 0; i < 3; i++) begin
                pc[i] <= 4'd0;
                dc[i] <= 4'd0;
                deck_p[i] = tie_mode ? 4'd0 : 4'($urandom_range(0, 9));
                deck_d[i] = tie_mode ? 4'd0 : 4'($urandom_range(0, 9));
            end
        end
        for (int i = 0; i < 3; i++) begin
            if (load_pcard[i]) pc[i] <= deck_p[i];
            if (load_dcard[i]) dc[i] <= deck_d[i];
        end
    end

    assign pscore = 4'((int'(pc[0]) + int'(pc[1]) + int'(pc[2])) % 10);
    assign dscore = 4'((int'(dc[0]) + int'(dc[1]) + int'(dc[2])) % 10);
    assign pcard3 = pc[2];

    // Reference: play the round from the deck by the table rules.
    int exp_p, exp_d, exp_t, exp_r;
    int cnt_p3, cnt_d3;
    logic [1:0] prev_l = 2'b00;

    always @(negedge slow_clock) begin
        int p2, d2, c, ps, ds;
        bit p3, d3;
        chk("onehot", 32'($countones({clear_hands, load_pcard, load_dcard}) <= 1), 1);
        if (clear_hands) begin cnt_p3 = 0; cnt_d3 = 0; end
        if (load_pcard[2]) cnt_p3++;
        if (load_dcard[2]) cnt_d3++;
        if (resetb && {player_win_light, dealer_win_light} != 2'b00 && prev_l == 2'b00) begin
            p2 = (deck_p[0] + deck_p[1]) % 10;
            d2 = (deck_d[0] + deck_d[1]) % 10;
            c  = deck_p[2];
            p3 = 0; d3 = 0;
            if (p2 < 8 && d2 < 8) begin
                if (p2 <= 5) begin
                    p3 = 1;
                    if (d2 <= 2)      d3 = 1;
                    else if (d2 == 3) d3 = (c != 8);
                    else if (d2 == 4) d3 = (c >= 2 && c <= 7);
                    else if (d2 == 5) d3 = (c >= 4 && c <= 7);
                    else if (d2 == 6) d3 = (c == 6 || c == 7);
                end else begin
                    d3 = (d2 <= 5);
                end
            end
            ps = (p2 + (p3 ? c : 0)) % 10;
            ds = (d2 + (d3 ? int'(deck_d[2]) : 0)) % 10;
            if (ps > ds)      exp_p = (exp_p < TMAX) ? exp_p + 1 : exp_p;
            else if (ds > ps) exp_d = (exp_d < TMAX) ? exp_d + 1 : exp_d;
            else              exp_t = (exp_t < TMAX) ? exp_t + 1 : exp_t;
            exp_r++;
            chk("lights", {player_win_light, dealer_win_light}, {30'd0, ps >= ds, ds >= ps});
            chk("p3_strobes", cnt_p3, p3);
            chk("d3_strobes", cnt_d3, d3);
            chk("player_wins", player_wins, exp_p);
            chk("dealer_wins", dealer_wins, exp_d);
            chk("ties", ties, exp_t);
            chk("round_num", round_num, exp_r);
            chk("busy_hold", busy, 1);
        end
        prev_l = {player_win_light, dealer_win_light};
    end

    task automatic go();
        exp_p = 0; exp_d = 0; exp_t = 0; exp_r = 0;
        start = 1'b1;
        @(negedge slow_clock);
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int k = 0;
        while (!match_done && k < budget) begin
            @(negedge slow_clock);
            k++;
        end
        chk("done_seen", match_done, 1);
    endtask

    function automatic logic [31:0] all_outs();
        return 32'({clear_hands, load_pcard, load_dcard, player_win_light, dealer_win_light,
                    player_wins, dealer_wins, ties, round_num, busy, match_done});
    endfunction

    initial begin
        int k;
        exp_p = 0; exp_d = 0; exp_t = 0; exp_r = 0;
        repeat (3) @(negedge slow_clock);
        chk("reset_outs", all_outs(), 0);
        resetb = 1'b1;
        @(negedge slow_clock);
        chk("idle_busy", busy, 0);

        // Random match, with a start pulse while busy that must be ignored.
        for (int m = 0; m < 3; m++) begin
            go();
            repeat (6) @(negedge slow_clock);
            chk("busy_mid", busy, 1);
            start = 1'b1;
            @(negedge slow_clock);
            start = 1'b0;
            wait_done(400);
            chk("final_rounds", round_num, ROUNDS);
            chk("done_busy", busy, 0);
            repeat (3) @(negedge slow_clock);
            chk("done_held", match_done, 1);
            chk("done_rounds_held", round_num, ROUNDS);
        end

        // All-zero decks: every round ties, tally saturates.
        tie_mode = 1'b1;
        go();
        wait_done(400);
        chk("ties_sat", ties, TMAX);
        chk("tie_pwins", player_wins, 0);
        tie_mode = 1'b0;

        // Reset while in P2.
        go();
        k = 0;
        while (!load_pcard[1] && k < 100) begin
            @(negedge slow_clock);
            k++;
        end
        chk("reach_p2", load_pcard[1], 1);
        resetb = 1'b0;
        @(negedge slow_clock);
        chk("midreset_outs", all_outs(), 0);
        resetb = 1'b1;
        @(negedge slow_clock);
        chk("after_reset_idle", busy, 0);
        go();
        chk("restart_clr", clear_hands, 1);
        @(negedge slow_clock);
        chk("restart_p1", load_pcard, 3'b001);
        @(negedge slow_clock);
        chk("restart_d1", load_dcard, 3'b001);
        wait_done(400);
        chk("final_rounds2", round_num, ROUNDS);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
